// File: rtl/voice_alloc_pkg.sv
// Shared types, the PS/2 set-2 scancode-to-note map and the note frequency ROM
// used by the voice allocator and its per-voice envelopes.
package voice_alloc_pkg;

    localparam int NUM_VOICES  = 8;
    localparam int VOICE_W     = $clog2(NUM_VOICES);
    localparam int BASE_OCTAVE = 4;

    typedef logic [6:0] note_t;

    localparam note_t NOTE_BASE = note_t'(12 * (BASE_OCTAVE + 1));

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_SCAN   = 2'd1;
    localparam logic [1:0] ST_COMMIT = 2'd2;

    typedef struct packed {
        note_t       tag;
        logic        held;
        logic [31:0] vol;
        logic [31:0] freq;
    } voice_t;

    typedef struct packed {
        logic  valid;
        note_t note;
    } note_lookup_t;

    typedef struct packed {
        logic  pressed;
        note_t note;
    } key_evt_t;

    typedef logic [127:0][31:0] freq_rom_t;

    function automatic note_lookup_t scancode_to_note(input logic [7:0] code);
        note_lookup_t r;
        logic [4:0]   off;
        off     = '0;
        r.valid = 1'b1;
        case (code)
            8'h1A: off = 5'd0;   8'h1B: off = 5'd1;   8'h22: off = 5'd2;
            8'h23: off = 5'd3;   8'h21: off = 5'd4;   8'h2A: off = 5'd5;
            8'h34: off = 5'd6;   8'h32: off = 5'd7;   8'h33: off = 5'd8;
            8'h31: off = 5'd9;   8'h3B: off = 5'd10;  8'h3A: off = 5'd11;
            8'h41: off = 5'd12;
            8'h15: off = 5'd12;  8'h1E: off = 5'd13;  8'h1D: off = 5'd14;
            8'h26: off = 5'd15;  8'h24: off = 5'd16;  8'h2D: off = 5'd17;
            8'h2E: off = 5'd18;  8'h2C: off = 5'd19;  8'h36: off = 5'd20;
            8'h35: off = 5'd21;  8'h3D: off = 5'd22;  8'h3C: off = 5'd23;
            8'h43: off = 5'd24;
            default: r.valid = 1'b0;
        endcase
        r.note = NOTE_BASE + note_t'(off);
        return r;
    endfunction

    // Octave 9 (C8..B8) in Q24.8; other octaves are derived by rounded shifts.
    function automatic logic [31:0] note_freq(input int n);
        logic [31:0] base;
        int          oct;
        int          s;
        case (n % 12)
            0:       base = 32'd1071618;
            1:       base = 32'd1135340;
            2:       base = 32'd1202851;
            3:       base = 32'd1274376;
            4:       base = 32'd1350154;
            5:       base = 32'd1430439;
            6:       base = 32'd1515497;
            7:       base = 32'd1605613;
            8:       base = 32'd1701088;
            9:       base = 32'd1802240;
            10:      base = 32'd1909407;
            default: base = 32'd2022946;
        endcase
        oct = n / 12;
        if (oct >= 9) begin
            return base << (oct - 9);
        end
        s = 9 - oct;
        return (base + (32'd1 << (s - 1))) >> s;
    endfunction

    function automatic freq_rom_t build_note_freq();
        freq_rom_t rom;
        for (int n = 0; n < 128; n++) begin
            rom[n] = note_freq(n);
        end
        return rom;
    endfunction

    localparam freq_rom_t NOTE_FREQ = build_note_freq();

endpackage

// File: rtl/voice_envelope.sv
// Linear attack/release volume ramp for one voice, saturating at 0 and VOL_MAX.
module voice_envelope import voice_alloc_pkg::*; #(
    parameter logic [31:0] VOL_MAX      = 32'h0000_FFFF,
    parameter logic [31:0] ATTACK_STEP  = 32'd512,
    parameter logic [31:0] RELEASE_STEP = 32'd256
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        tick,
    input  logic        held,
    input  logic        load_zero,
    output logic [31:0] vol
);

    logic [32:0] up;
    logic [32:0] down;

    assign up   = {1'b0, vol} + {1'b0, ATTACK_STEP};
    assign down = {1'b0, vol} - {1'b0, RELEASE_STEP};

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            vol <= '0;
        end else if (load_zero) begin
            vol <= '0;
        end else if (tick) begin
            if (held) begin
                vol <= (up > {1'b0, VOL_MAX}) ? VOL_MAX : up[31:0];
            end else begin
                vol <= down[32] ? 32'd0 : down[31:0];
            end
        end
    end

endmodule

// File: rtl/ps2_voice_allocator.sv
// Turns ps2_key toggle events into note-on/off and assigns them to synth voices,
// scanning voices one per cycle and stealing round-robin when all are busy.
module ps2_voice_allocator import voice_alloc_pkg::*; #(
    parameter logic [31:0] VOL_MAX      = 32'h0000_FFFF,
    parameter logic [31:0] ATTACK_STEP  = 32'd512,
    parameter logic [31:0] RELEASE_STEP = 32'd256,
    parameter int          ENV_DIV      = 24000
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [10:0]           ps2_key,
    output logic [31:0]           frequencies   [NUM_VOICES],
    output logic [31:0]           voice_volumes [NUM_VOICES],
    output logic [NUM_VOICES-1:0] active_mask,
    output logic                  busy,
    output logic [7:0]            dropped_events
);

    localparam int CNT_W = (ENV_DIV > 1) ? $clog2(ENV_DIV) : 1;

    logic               armed;
    logic               prev_toggle;
    logic               ev_raw;
    logic               ev_ok;
    note_lookup_t       lk;
    key_evt_t           ev_in;
    key_evt_t           pend;
    key_evt_t           cur;
    logic               pend_valid;
    logic [1:0]         state;
    logic [VOICE_W-1:0] scan_idx;
    logic [VOICE_W-1:0] steal_ptr;
    logic [VOICE_W-1:0] idle_idx;
    logic [VOICE_W-1:0] rel_idx;
    logic [VOICE_W-1:0] match_idx;
    logic [VOICE_W-1:0] target_idx;
    logic               found_idle;
    logic               found_rel;
    logic               found_match;
    logic               do_press;
    logic               do_release;
    logic               target_zero;
    logic               do_steal;
    logic [NUM_VOICES-1:0] hit;
    logic [NUM_VOICES-1:0] load_zero;
    logic [NUM_VOICES-1:0] held_q;
    note_t              tag_q   [NUM_VOICES];
    logic [31:0]        freq_q  [NUM_VOICES];
    logic [31:0]        env_vol [NUM_VOICES];
    voice_t             voices  [NUM_VOICES];
    voice_t             scan_v;
    logic [CNT_W-1:0]   env_cnt;
    logic               env_tick;

    // Event handshake: ps2_key[10] flips once per key event and the other bits are
    // stable alongside it; there is no back-pressure, so anything that cannot be
    // queued is counted in dropped_events.
    assign lk     = scancode_to_note(ps2_key[7:0]);
    assign ev_raw = armed && (ps2_key[10] != prev_toggle);
    assign ev_ok  = ev_raw && !ps2_key[8] && lk.valid;
    assign ev_in  = '{pressed: ps2_key[9], note: lk.note};
    assign scan_v = voices[scan_idx];
    assign busy   = (state != ST_IDLE);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            armed          <= 1'b0;
            prev_toggle    <= 1'b0;
            state          <= ST_IDLE;
            scan_idx       <= '0;
            pend           <= '0;
            pend_valid     <= 1'b0;
            cur            <= '0;
            found_idle     <= 1'b0;
            found_rel      <= 1'b0;
            found_match    <= 1'b0;
            idle_idx       <= '0;
            rel_idx        <= '0;
            match_idx      <= '0;
            dropped_events <= '0;
        end else begin
            if (!armed) begin
                armed       <= 1'b1;
                prev_toggle <= ps2_key[10];
            end else if (ev_raw) begin
                prev_toggle <= ps2_key[10];
            end

            case (state)
                ST_IDLE: begin
                    scan_idx    <= '0;
                    found_idle  <= 1'b0;
                    found_rel   <= 1'b0;
                    found_match <= 1'b0;
                    if (pend_valid) begin
                        cur        <= pend;
                        state      <= ST_SCAN;
                        pend       <= ev_in;
                        pend_valid <= ev_ok;
                    end else if (ev_ok) begin
                        cur   <= ev_in;
                        state <= ST_SCAN;
                    end
                end
                ST_SCAN: begin
                    if (!scan_v.held && scan_v.vol == '0 && !found_idle) begin
                        found_idle <= 1'b1;
                        idle_idx   <= scan_idx;
                    end
                    if (!scan_v.held && scan_v.vol != '0 && !found_rel) begin
                        found_rel <= 1'b1;
                        rel_idx   <= scan_idx;
                    end
                    if (scan_v.held && scan_v.tag == cur.note && !found_match) begin
                        found_match <= 1'b1;
                        match_idx   <= scan_idx;
                    end
                    if (scan_idx == VOICE_W'(NUM_VOICES - 1)) begin
                        state <= ST_COMMIT;
                    end else begin
                        scan_idx <= scan_idx + 1'b1;
                    end
                end
                default: state <= ST_IDLE;
            endcase

            if (state != ST_IDLE && ev_ok) begin
                pend       <= ev_in;
                pend_valid <= 1'b1;
                if (pend_valid && dropped_events != 8'hFF) begin
                    dropped_events <= dropped_events + 8'd1;
                end
            end
        end
    end

    // A held match means typematic repeat on press; otherwise idle > releasing > steal.
    always_comb begin
        do_press    = 1'b0;
        do_release  = 1'b0;
        do_steal    = 1'b0;
        target_zero = 1'b0;
        target_idx  = steal_ptr;
        hit         = '0;
        load_zero   = '0;
        if (state == ST_COMMIT) begin
            if (cur.pressed) begin
                if (!found_match) begin
                    do_press = 1'b1;
                    if (found_idle) begin
                        target_idx  = idle_idx;
                        target_zero = 1'b1;
                    end else if (found_rel) begin
                        target_idx = rel_idx;
                    end else begin
                        target_zero = 1'b1;
                        do_steal    = 1'b1;
                    end
                end
            end else if (found_match) begin
                do_release = 1'b1;
                target_idx = match_idx;
            end
        end
        for (int i = 0; i < NUM_VOICES; i++) begin
            if ((do_press || do_release) && target_idx == VOICE_W'(i)) begin
                hit[i]       = 1'b1;
                load_zero[i] = do_press && target_zero;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            held_q    <= '0;
            steal_ptr <= '0;
            for (int i = 0; i < NUM_VOICES; i++) begin
                tag_q[i]  <= '0;
                freq_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_VOICES; i++) begin
                if (hit[i]) begin
                    held_q[i] <= do_press;
                    if (do_press) begin
                        tag_q[i]  <= cur.note;
                        freq_q[i] <= NOTE_FREQ[cur.note];
                    end
                end
            end
            if (do_steal) begin
                steal_ptr <= (steal_ptr == VOICE_W'(NUM_VOICES - 1)) ? '0 : steal_ptr + 1'b1;
            end
        end
    end

    assign env_tick = (env_cnt == CNT_W'(ENV_DIV - 1));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            env_cnt <= '0;
        end else begin
            env_cnt <= env_tick ? '0 : env_cnt + 1'b1;
        end
    end

    // A commit on a voice owns that voice for the cycle, so its tick is dropped.
    for (genvar i = 0; i < NUM_VOICES; i++) begin : g_voice
        voice_envelope #(
            .VOL_MAX      (VOL_MAX),
            .ATTACK_STEP  (ATTACK_STEP),
            .RELEASE_STEP (RELEASE_STEP)
        ) u_env (
            .clk       (clk),
            .reset     (reset),
            .tick      (env_tick && !hit[i]),
            .held      (held_q[i]),
            .load_zero (load_zero[i]),
            .vol       (env_vol[i])
        );

        assign voices[i]        = '{tag: tag_q[i], held: held_q[i], vol: env_vol[i], freq: freq_q[i]};
        assign frequencies[i]   = voices[i].freq;
        assign voice_volumes[i] = voices[i].vol;
        assign active_mask[i]   = voices[i].held | (voices[i].vol != '0);
    end

endmodule

// File: tb/tb_ps2_voice_allocator.sv
// Directed bench for ps2_voice_allocator: key events are driven, the expected
// commit result is queued, and a monitor checks it when busy falls.
module tb_ps2_voice_allocator;

    localparam int NV = 8;
    localparam int W  = 77;  // {voice[3:0], freq[31:0], mask[7:0], vol_chk, vol[31:0]}

    logic        clk;
    logic        reset;
    logic [10:0] ps2_key;
    logic [31:0] frequencies   [NV];
    logic [31:0] voice_volumes [NV];
    logic [7:0]  active_mask;
    logic        busy;
    logic [7:0]  dropped_events;

    logic [W-1:0] exp_q[$];
    int n_vec;
    int n_bad;

    ps2_voice_allocator #(.ENV_DIV(4)) dut (
        .clk            (clk),
        .reset          (reset),
        .ps2_key        (ps2_key),
        .frequencies    (frequencies),
        .voice_volumes  (voice_volumes),
        .active_mask    (active_mask),
        .busy           (busy),
        .dropped_events (dropped_events)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic do_reset();
        reset = 1'b1;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // drivers
    task automatic send_key(input logic pressed, input logic ext, input logic [7:0] code);
        @(negedge clk);
        ps2_key = {~ps2_key[10], pressed, ext, code};
    endtask

    task automatic push_exp(input int v, input logic [31:0] f, input logic [7:0] m,
                            input logic vc, input logic [31:0] vol);
        exp_q.push_back({4'(v), f, m, vc, vol});
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        @(negedge clk);
        while (busy && n < 40) begin
            @(negedge clk);
            n++;
        end
        chk("idle_timeout", {31'd0, busy}, 32'd0);
    endtask

    task automatic report();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    endtask

    // scoreboard monitor: one expectation per falling edge of busy
    initial begin
        logic         busy_d;
        logic [W-1:0] e;
        int           idx;
        busy_d = 1'b0;
        forever begin
            @(negedge clk);
            if (busy_d && !busy && !reset) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_commit", 32'd1, 32'd0);
                end else begin
                    e   = exp_q.pop_front();
                    idx = int'(e[76:73]);
                    chk("commit_freq", frequencies[idx], e[72:41]);
                    chk("commit_mask", {24'd0, active_mask}, {24'd0, e[40:33]});
                    if (e[32]) begin
                        chk("commit_vol", voice_volumes[idx], e[31:0]);
                    end
                end
            end
            busy_d = busy;
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout, expected completion");
        n_vec++;
        n_bad++;
        report();
        $finish;
    end

    initial begin
        logic [7:0]  codes [10];
        logic [31:0] freqs [10];
        logic [31:0] acc;
        logic        seen;
        int          v;
        codes = '{8'h1A, 8'h22, 8'h21, 8'h2A, 8'h32, 8'h31, 8'h3A, 8'h15, 8'h1D, 8'h24};
        freqs = '{32'd66976, 32'd75178, 32'd84385, 32'd89402, 32'd100351,
                  32'd112640, 32'd126434, 32'd133952, 32'd150356, 32'd168769};
        n_vec   = 0;
        n_bad   = 0;
        ps2_key = '0;
        do_reset();

        acc = '0;
        for (int i = 0; i < NV; i++) acc |= frequencies[i] | voice_volumes[i];
        chk("reset_freq_vol", acc, 32'd0);
        chk("reset_mask", {24'd0, active_mask}, 32'd0);
        chk("reset_busy", {31'd0, busy}, 32'd0);
        chk("reset_dropped", {24'd0, dropped_events}, 32'd0);

        // single press: latency, attack ramp, saturation
        send_key(1'b1, 1'b0, 8'h1A);
        push_exp(0, 32'h0001_05A0, 8'h01, 1'b1, 32'd0);
        @(posedge clk);
        repeat (8) @(posedge clk);
        #1;
        chk("busy_in_scan", {31'd0, busy}, 32'd1);
        chk("freq_before_commit", frequencies[0], 32'd0);
        @(posedge clk);
        #1;
        chk("busy_after_commit", {31'd0, busy}, 32'd0);
        chk("freq_at_n9", frequencies[0], 32'h0001_05A0);
        repeat (40) @(negedge clk);
        chk("attack_step_align", {23'd0, voice_volumes[0][8:0]}, 32'd0);
        chk("attack_nonzero", {31'd0, voice_volumes[0] != 32'd0}, 32'd1);
        repeat (600) @(negedge clk);
        chk("attack_saturated", voice_volumes[0], 32'h0000_FFFF);
        chk("mask_held", {24'd0, active_mask}, 32'h01);

        // typematic repeat, then release and decay
        send_key(1'b1, 1'b0, 8'h1A);
        push_exp(0, 32'h0001_05A0, 8'h01, 1'b1, 32'h0000_FFFF);
        wait_idle();
        send_key(1'b0, 1'b0, 8'h1A);
        push_exp(0, 32'h0001_05A0, 8'h01, 1'b0, 32'd0);
        wait_idle();
        repeat (100) @(negedge clk);
        chk("release_step_align", {24'd0, voice_volumes[0][7:0]}, 32'hFF);
        chk("release_falling", {31'd0, voice_volumes[0] < 32'h0000_FFFF}, 32'd1);
        repeat (1100) @(negedge clk);
        chk("release_floor", voice_volumes[0], 32'd0);
        chk("mask_released", {24'd0, active_mask}, 32'd0);
        chk("freq_persists", frequencies[0], 32'h0001_05A0);

        // fill all voices, then steal voice 0 and voice 1
        do_reset();
        for (int i = 0; i < 10; i++) begin
            v = (i < NV) ? i : i - NV;
            send_key(1'b1, 1'b0, codes[i]);
            push_exp(v, freqs[i], (i < NV) ? 8'((1 << (i + 1)) - 1) : 8'hFF, 1'b1, 32'd0);
            repeat (11) @(negedge clk);
        end
        chk("untouched_voice2", frequencies[2], 32'd84385);

        // overlapping events: second is overwritten by the third
        do_reset();
        send_key(1'b1, 1'b0, 8'h1A);
        send_key(1'b1, 1'b0, 8'h22);
        send_key(1'b1, 1'b0, 8'h21);
        push_exp(0, 32'd66976, 8'h01, 1'b1, 32'd0);
        push_exp(1, 32'd84385, 8'h03, 1'b1, 32'd0);
        repeat (30) @(negedge clk);
        chk("dropped_one", {24'd0, dropped_events}, 32'd1);
        chk("overwritten_voice2", frequencies[2], 32'd0);

        // extended and unmapped keys are ignored
        send_key(1'b1, 1'b1, 8'h1A);
        send_key(1'b1, 1'b0, 8'h76);
        seen = 1'b0;
        repeat (6) begin
            @(negedge clk);
            seen |= busy;
        end
        chk("ignored_busy", {31'd0, seen}, 32'd0);
        chk("ignored_mask", {24'd0, active_mask}, 32'h03);
        chk("ignored_dropped", {24'd0, dropped_events}, 32'd1);

        // reset in the middle of a scan
        send_key(1'b1, 1'b0, 8'h2A);
        repeat (3) @(posedge clk);
        #1 reset = 1'b1;
        #1;
        chk("async_busy", {31'd0, busy}, 32'd0);
        chk("async_mask", {24'd0, active_mask}, 32'd0);
        chk("async_dropped", {24'd0, dropped_events}, 32'd0);
        chk("async_freq0", frequencies[0], 32'd0);
        chk("async_vol1", voice_volumes[1], 32'd0);
        ps2_key[10] = ~ps2_key[10];
        repeat (2) @(negedge clk);
        reset = 1'b0;
        seen  = 1'b0;
        repeat (6) begin
            @(negedge clk);
            seen |= busy;
        end
        chk("rearm_no_event", {31'd0, seen}, 32'd0);
        send_key(1'b1, 1'b0, 8'h1A);
        push_exp(0, 32'd66976, 8'h01, 1'b1, 32'd0);
        wait_idle();

        repeat (5) @(negedge clk);
        chk("queue_drained", exp_q.size(), 32'd0);
        report();
        $finish;
    end

endmodule
